exc_commit: RTL and testbench

Exception commit unit at the writeback boundary, immediately upstream of the CP0 register file. It takes the per-instruction exception flags and `eret` marker of the committing instruction, plus the CP0 `has_int` line. It arbitrates them, drives the CP0 exception-write inputs (`ex_ex`, `ex_bd`, `ex_pc`, `ex_excode`, `ex_badvaddr`, `eret_flush`), and flushes the pipeline. It then holds a redirect request to fetch until fetch accepts it.

---
 rtl/exc_pkg.sv | 36 +++
 rtl/exc_prio_enc.sv | 41 ++++
 rtl/exc_commit.sv | 103 ++++++++++
 tb/tb_exc_commit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// Shared exception definitions for the commit unit and CP0: excodes, flag bit positions,
// badvaddr source select, default exception vector and commit FSM encoding.
package exc_pkg;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  // ws_exc = {ades, adel_ls, bp, sys, ov, ri, adel_if}
  localparam int EXB_ADEL_IF = 0;
  localparam int EXB_RI      = 1;
  localparam int EXB_OV      = 2;
  localparam int EXB_SYS     = 3;
  localparam int EXB_BP      = 4;
  localparam int EXB_ADEL_LS = 5;
  localparam int EXB_ADES    = 6;
  localparam int EXB_W       = 7;

  typedef enum logic [1:0] {
    BAD_NONE = 2'd0,
    BAD_PC   = 2'd1,
    BAD_DATA = 2'd2
  } bad_sel_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_REDIR = 1'b1
  } exc_state_e;

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority exception cause encoder, purely combinational (0 cycles, no backpressure).
// Interrupt outranks every instruction flag; fetch-side faults outrank execute-side ones.
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic             int_q,
  input  logic [EXB_W-1:0] ws_exc,
  output logic             take,
  output logic [4:0]       excode,
  output bad_sel_e         bad_sel
);

  always_comb begin
    take    = 1'b1;
    excode  = EXC_INT;
    bad_sel = BAD_NONE;
    if (int_q) begin
      excode = EXC_INT;
    end else if (ws_exc[EXB_ADEL_IF]) begin
      excode  = EXC_ADEL;
      bad_sel = BAD_PC;
    end else if (ws_exc[EXB_RI]) begin
      excode = EXC_RI;
    end else if (ws_exc[EXB_OV]) begin
      excode = EXC_OV;
    end else if (ws_exc[EXB_SYS]) begin
      excode = EXC_SYS;
    end else if (ws_exc[EXB_BP]) begin
      excode = EXC_BP;
    end else if (ws_exc[EXB_ADEL_LS]) begin
      excode  = EXC_ADEL;
      bad_sel = BAD_DATA;
    end else if (ws_exc[EXB_ADES]) begin
      excode  = EXC_ADES;
      bad_sel = BAD_DATA;
    end else begin
      take = 1'b0;
    end
  end

endmodule

// File: rtl/exc_commit.sv
// Writeback exception/eret commit: CP0 write pulses in the commit cycle, redirect to fetch one cycle later.
// Redirect is held stable until redirect_ready; commits arriving meanwhile are ignored.
module exc_commit
  import exc_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ws_valid,
  input  logic [31:0]      ws_pc,
  input  logic             ws_bd,
  input  logic [EXB_W-1:0] ws_exc,
  input  logic [31:0]      ws_data_addr,
  input  logic             ws_eret,
  input  logic             has_int,
  input  logic [31:0]      cp0_epc,
  output logic             ex_ex,
  output logic             ex_bd,
  output logic [31:0]      ex_pc,
  output logic [4:0]       ex_excode,
  output logic [31:0]      ex_badvaddr,
  output logic             eret_flush,
  output logic             ws_retire,
  output logic             flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  input  logic             redirect_ready
);

  exc_state_e  state;
  logic [31:0] target;
  logic        int_q;

  logic        cause;
  logic [4:0]  excode;
  bad_sel_e    bad_sel;
  logic        in_idle;
  logic        take;
  logic        do_eret;

  exc_prio_enc u_prio (
    .int_q   (int_q),
    .ws_exc  (ws_exc),
    .take    (cause),
    .excode  (excode),
    .bad_sel (bad_sel)
  );

  assign in_idle = (state == ST_IDLE);
  assign take    = in_idle & ws_valid & cause;
  assign do_eret = in_idle & ws_valid & ws_eret & ~cause;

  // Payload is forced to zero unless an exception is actually being taken.
  always_comb begin
    ex_ex          = take;
    ex_bd          = 1'b0;
    ex_pc          = 32'h0;
    ex_excode      = 5'h0;
    ex_badvaddr    = 32'h0;
    eret_flush     = do_eret;
    ws_retire      = in_idle & ws_valid & ~cause;
    flush          = take | do_eret | ~in_idle;
    redirect_valid = ~in_idle;
    redirect_pc    = in_idle ? 32'h0 : target;
    if (take) begin
      ex_bd     = ws_bd;
      ex_pc     = ws_pc;
      ex_excode = excode;
      case (bad_sel)
        BAD_PC:   ex_badvaddr = ws_pc;
        BAD_DATA: ex_badvaddr = ws_data_addr;
        default:  ex_badvaddr = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= ST_IDLE;
      target <= 32'h0;
      int_q  <= 1'b0;
    end else begin
      int_q <= has_int;
      case (state)
        ST_IDLE: begin
          if (take) begin
            target <= EXC_VECTOR;
            state  <= ST_REDIR;
          end else if (do_eret) begin
            target <= cp0_epc;
            state  <= ST_REDIR;
          end
        end
        ST_REDIR: begin
          if (redirect_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_commit.sv
// Scoreboard bench for exc_commit: directed commits push expected output sets, a negedge monitor pops and compares.
module tb_exc_commit;

  typedef struct packed {
    logic        ex_ex;
    logic        ex_bd;
    logic [31:0] ex_pc;
    logic [4:0]  ex_excode;
    logic [31:0] ex_badvaddr;
    logic        eret_flush;
    logic        ws_retire;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ws_valid;
  logic [31:0] ws_pc;
  logic        ws_bd;
  logic [6:0]  ws_exc;
  logic [31:0] ws_data_addr;
  logic        ws_eret;
  logic        has_int;
  logic [31:0] cp0_epc;
  logic        redirect_ready;
  logic        ex_ex, ex_bd, eret_flush, ws_retire, flush, redirect_valid;
  logic [31:0] ex_pc, ex_badvaddr, redirect_pc;
  logic [4:0]  ex_excode;

  int   checks = 0;
  int   errors = 0;
  logic done   = 1'b0;
  exp_t exp_q[$];
  string nm_q[$];
  exp_t act;

  always #5 clk = ~clk;

  exc_commit dut (
    .clk            (clk),
    .resetn         (resetn),
    .ws_valid       (ws_valid),
    .ws_pc          (ws_pc),
    .ws_bd          (ws_bd),
    .ws_exc         (ws_exc),
    .ws_data_addr   (ws_data_addr),
    .ws_eret        (ws_eret),
    .has_int        (has_int),
    .cp0_epc        (cp0_epc),
    .ex_ex          (ex_ex),
    .ex_bd          (ex_bd),
    .ex_pc          (ex_pc),
    .ex_excode      (ex_excode),
    .ex_badvaddr    (ex_badvaddr),
    .eret_flush     (eret_flush),
    .ws_retire      (ws_retire),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready)
  );

  always_comb act = '{ex_ex, ex_bd, ex_pc, ex_excode, ex_badvaddr,
                      eret_flush, ws_retire, flush, redirect_valid, redirect_pc};

  function automatic exp_t e_ex(input logic bd, input logic [31:0] pc,
                                input logic [4:0] code, input logic [31:0] bad);
    exp_t e = '0;
    e.ex_ex = 1'b1; e.ex_bd = bd; e.ex_pc = pc; e.ex_excode = code;
    e.ex_badvaddr = bad; e.flush = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_redir(input logic [31:0] pc);
    exp_t e = '0;
    e.redirect_valid = 1'b1; e.redirect_pc = pc; e.flush = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_retire();
    exp_t e = '0;
    e.ws_retire = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_eret();
    exp_t e = '0;
    e.eret_flush = 1'b1; e.ws_retire = 1'b1; e.flush = 1'b1;
    return e;
  endfunction

  task automatic expect_out(input string nm, input exp_t e);
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic bd, input logic [6:0] exc,
                       input logic [31:0] addr, input logic er, input logic rdy);
    ws_valid = v; ws_pc = pc; ws_bd = bd; ws_exc = exc;
    ws_data_addr = addr; ws_eret = er; redirect_ready = rdy;
  endtask

  // Monitor: any active output must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!done && (ex_ex || eret_flush || ws_retire || flush || redirect_valid)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got ex_ex=%b eret=%b ret=%b flush=%b rv=%b rpc=%h, required no activity",
                 ex_ex, eret_flush, ws_retire, flush, redirect_valid, redirect_pc);
      end else begin
        exp_t  e;
        string nm;
        e  = exp_q.pop_front();
        nm = nm_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL %s: got ex=%b bd=%b pc=%h code=%h bad=%h eret=%b ret=%b fl=%b rv=%b rpc=%h, required ex=%b bd=%b pc=%h code=%h bad=%h eret=%b ret=%b fl=%b rv=%b rpc=%h",
                   nm, act.ex_ex, act.ex_bd, act.ex_pc, act.ex_excode, act.ex_badvaddr, act.eret_flush,
                   act.ws_retire, act.flush, act.redirect_valid, act.redirect_pc,
                   e.ex_ex, e.ex_bd, e.ex_pc, e.ex_excode, e.ex_badvaddr, e.eret_flush,
                   e.ws_retire, e.flush, e.redirect_valid, e.redirect_pc);
        end
      end
    end
  end

  initial begin
    resetn = 1'b0; has_int = 1'b0; cp0_epc = 32'h0;
    drive(1'b0, 32'h0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b0);
    repeat (3) step();
    @(negedge clk);
    checks++;
    if (act !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0", act);
    end
    step();
    resetn = 1'b1;

    // ov: vector redirect, ready on first redirect cycle
    drive(1'b1, 32'h8000_0010, 1'b0, 7'b000_0100, 32'hDEAD_0000, 1'b0, 1'b0);
    expect_out("ov_take", e_ex(1'b0, 32'h8000_0010, 5'h0c, 32'h0));
    step();
    drive(1'b0, 32'h0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b1);
    expect_out("ov_redirect", e_redir(32'hBFC0_0380));
    step();

    // adel_ls in delay slot: badvaddr from data address
    drive(1'b1, 32'h8000_0020, 1'b1, 7'b010_0000, 32'h1234_5671, 1'b0, 1'b0);
    expect_out("adel_ls_take", e_ex(1'b1, 32'h8000_0020, 5'h04, 32'h1234_5671));
    step();
    drive(1'b0, 32'h0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b1);
    expect_out("adel_ls_redirect", e_redir(32'hBFC0_0380));
    step();

    // adel_if beats ri, badvaddr from pc
    drive(1'b1, 32'h8000_0031, 1'b0, 7'b000_0011, 32'h5555_5555, 1'b0, 1'b0);
    expect_out("adel_if_prio", e_ex(1'b0, 32'h8000_0031, 5'h04, 32'h8000_0031));
    step();
    drive(1'b0, 32'h0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b1);
    expect_out("adel_if_redirect", e_redir(32'hBFC0_0380));
    step();

    // ades with eret: exception wins, no eret_flush
    drive(1'b1, 32'h8000_0040, 1'b0, 7'b100_0000, 32'hA000_0003, 1'b1, 1'b0);
    cp0_epc = 32'h8000_0999;
    expect_out("ades_over_eret", e_ex(1'b0, 32'h8000_0040, 5'h05, 32'hA000_0003));
    step();
    drive(1'b0, 32'h0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b1);
    expect_out("ades_redirect", e_redir(32'hBFC0_0380));
    step();

    // ri beats ov and sys
    drive(1'b1, 32'h8000_0050, 1'b1, 7'b000_1110, 32'h1111_1111, 1'b0, 1'b0);
    expect_out("ri_prio", e_ex(1'b1, 32'h8000_0050, 5'h0a, 32'h0));
    step();
    drive(1'b0, 32'h0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b1);
    expect_out("ri_redirect", e_redir(32'hBFC0_0380));
    step();

    // bp beats adel_ls, no badvaddr
    drive(1'b1, 32'h8000_0060, 1'b0, 7'b011_0000, 32'h2222_2222, 1'b0, 1'b0);
    expect_out("bp_prio", e_ex(1'b0, 32'h8000_0060, 5'h09, 32'h0));
    step();
    drive(1'b0, 32'h0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b1);
    expect_out("bp_redirect", e_redir(32'hBFC0_0380));
    step();

    // has_int in the same cycle as commit is not yet visible
    has_int = 1'b1;
    drive(1'b1, 32'h8000_0070, 1'b0, 7'b000_1000, 32'h0, 1'b0, 1'b0);
    expect_out("int_not_yet", e_ex(1'b0, 32'h8000_0070, 5'h08, 32'h0));
    step();
    has_int = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b1);
    expect_out("int_not_yet_redirect", e_redir(32'hBFC0_0380));
    step();

    // has_int pulse, then commit with sys: interrupt wins
    has_int = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b0);
    step();
    has_int = 1'b0;
    drive(1'b1, 32'h8000_0080, 1'b1, 7'b000_1000, 32'h3333_3333, 1'b0, 1'b0);
    expect_out("int_wins", e_ex(1'b1, 32'h8000_0080, 5'h00, 32'h0));
    step();
    drive(1'b0, 32'h0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b1);
    expect_out("int_redirect", e_redir(32'hBFC0_0380));
    step();

    // eret: redirect to EPC held through three stalled cycles and an ignored ri commit
    cp0_epc = 32'h8000_0100;
    drive(1'b1, 32'h8000_0090, 1'b0, 7'h00, 32'h0, 1'b1, 1'b0);
    expect_out("eret_commit", e_eret());
    step();
    cp0_epc = 32'h0;
    drive(1'b0, 32'h0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      expect_out($sformatf("eret_hold%0d", i), e_redir(32'h8000_0100));
      step();
    end
    drive(1'b1, 32'h8000_00A0, 1'b0, 7'b000_0010, 32'h0, 1'b0, 1'b0);
    expect_out("redir_ignores_ri", e_redir(32'h8000_0100));
    step();
    drive(1'b0, 32'h0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b1);
    expect_out("eret_accept", e_redir(32'h8000_0100));
    step();

    // clean commit right after accept; ready in IDLE is ignored
    drive(1'b1, 32'h8000_00B0, 1'b1, 7'h00, 32'h4444_4444, 1'b0, 1'b1);
    expect_out("clean_after_redir", e_retire());
    step();

    // reset while in REDIR abandons the redirect
    drive(1'b1, 32'h8000_00C0, 1'b0, 7'b000_0100, 32'h0, 1'b0, 1'b0);
    expect_out("ov_before_reset", e_ex(1'b0, 32'h8000_00C0, 5'h0c, 32'h0));
    step();
    resetn = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b0);
    expect_out("redir_during_reset", e_redir(32'hBFC0_0380));
    step();
    resetn = 1'b1;
    step();
    drive(1'b1, 32'h8000_00D0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b0);
    expect_out("clean_after_reset", e_retire());
    step();
    drive(1'b0, 32'h0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b0);
    repeat (3) step();

    @(negedge clk);
    #1;
    done = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0 (next %s)", exp_q.size(), nm_q[0]);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
